fetch_redirect: RTL

FETCH_REDIRECT -- requirements
Module: fetch_redirect

---
 rtl/fetch_pkg.sv | 19 +
 rtl/sat_counter.sv | 24 ++
 rtl/fetch_redirect.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-redirect slice: pc width, reset
// vector, the fetch state enum and the wrapping pc increment.
package fetch_pkg;

    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] PC_RESET = 16'h0000;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } fetch_state_e;

    // Natural modulo-2^ADDR_W wrap: 16'hFFFF + 1 -> 16'h0000.
    function automatic logic [ADDR_W-1:0] pc_plus1(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping; cleared by the
// asynchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch pc generation with branch-misprediction recovery, halt handling and
// pipeline flush control. Define REDIRECT_STATS_EN to add miss counters.
module fetch_redirect
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump_pred,
    input  logic [ADDR_W-1:0] jump_pred_adr,
    input  logic              jump_pred_miss,
    input  logic              jump_pred_adr_miss,
    input  logic [ADDR_W-1:0] pcinc_evac,
    input  logic [ADDR_W-1:0] ALUres_mem,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pcinc_if,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic              fetch_valid
`ifdef REDIRECT_STATS_EN
    ,
    output logic [15:0]       miss_count,
    output logic [15:0]       adr_miss_count
`endif
);

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] pc_seq;
    logic              mem_miss;

    assign mem_miss = jump_pred_miss | jump_pred_adr_miss;
    assign pc_seq   = pc_plus1(pc_reg);

    // MEM-stage resolution outranks everything, including stall and halt;
    // while halted only an in-flight MEM redirect may move the pc.
    always_comb begin
        pc_next = pc_reg;
        if (jump_pred_adr_miss) begin
            pc_next = ALUres_mem;
        end else if (jump_pred_miss) begin
            pc_next = pcinc_evac;
        end else if (state_reg != HALTED) begin
            if (jump_pred) begin
                pc_next = jump_pred_adr;
            end else if (!stall) begin
                pc_next = pc_seq;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (mem_miss) begin
            state_next = RECOVER;
        end else begin
            case (state_reg)
                RUN:     state_next = halt ? HALTED : RUN;
                RECOVER: state_next = RUN;
                HALTED:  state_next = HALTED;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            pc_reg    <= PC_RESET;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    assign pc          = pc_reg;
    assign pcinc_if    = pc_seq;
    assign flush_exmem = mem_miss;
    assign flush_idex  = mem_miss;
    assign flush_ifid  = mem_miss | (jump_pred & (state_reg != HALTED));
    assign fetch_valid = (state_reg == RUN) & ~stall;

`ifdef REDIRECT_STATS_EN
    logic [1:0]  stat_inc;
    logic [15:0] stat_count [2];

    assign stat_inc = {jump_pred_adr_miss, jump_pred_miss};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            sat_counter #(.W(16)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (stat_inc[gi]),
                .count (stat_count[gi])
            );
        end
    endgenerate

    assign miss_count     = stat_count[0];
    assign adr_miss_count = stat_count[1];
`endif

endmodule
